// File: rtl/ramp_source_if.sv
// Control inputs and ramp outputs of ramp_source, bundled for the source (master)
// and the consumer / test driver (slave).
interface ramp_source_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             pause;
  logic [WIDTH-1:0] OutData;
  logic             valid;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   count;

  modport master (
    input  start, pause,
    output OutData, valid, busy, done, count
  );

  modport slave (
    output start, pause,
    input  OutData, valid, busy, done, count
  );
endinterface

// File: rtl/ramp_source.sv
// Ramp stimulus source: emits START_VAL, START_VAL+STEP, ... each held HOLD cycles,
// stopping once END_VAL has been held. An odd STEP makes bit 0 toggle on every value.
module ramp_source #(
  parameter int                 WIDTH     = 8,
  parameter int                 HOLD      = 4,
  parameter int                 STEP      = 1,
  parameter logic [WIDTH-1:0]   START_VAL = '0,
  parameter logic [WIDTH-1:0]   END_VAL   = '1
) (
  input logic          clk,
  input logic          rst,
  ramp_source_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [7:0]       HOLD_LAST = 8'(HOLD - 1);
  localparam logic [WIDTH-1:0] STEP_W    = WIDTH'(STEP);

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH:0]   r_count;
  logic [7:0]       r_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_count <= '0;
      r_hold  <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_state <= S_RUN;
            r_data  <= START_VAL;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_count <= (WIDTH+1)'(1);
            r_hold  <= '0;
          end
        end
        S_RUN: begin
          // pause freezes everything, including the final transition to DONE
          if (!bus.pause) begin
            if (r_hold == HOLD_LAST) begin
              if (r_data != END_VAL) begin
                r_data  <= r_data + STEP_W;
                r_valid <= 1'b1;
                r_count <= r_count + 1'b1;
                r_hold  <= '0;
              end else begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
              end
            end else begin
              r_hold <= r_hold + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.OutData = r_data;
  assign bus.valid   = r_valid;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.count   = r_count;

endmodule
